multiply_dispatcher: RTL and testbench
======================================

# multiply_dispatcher

Operand-side front end for the sequential `Multiplier`. It buffers operand pairs arriving on a valid/ready stream in a small FIFO and issues them one at a time to the multiplier with a single-cycle start pulse. It waits for the finished flag, then presents each `2N`-bit product on a valid/ready output stream, preserving order. It sits between the operand source and `Multiplier`, and owns the multiplier's start/operand inputs and its finished/product outputs.

## Interface

Clocking and reset (already decided): one clock, `i_clock`. Reset `i_reset` is asynchronous and active-low.

Parameters
- `N`, default 4: operand width; product width is `2N`.
- `DEPTH`, default 4: operand FIFO entries; power of two, ≥2.

Ports
- `i_clock`  in  1  sole clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  upstream operand pair valid.
- `o_ready`  out  1  FIFO can accept; high when `o_count < DEPTH`.
- `i_multiplicand`  in  N  upstream multiplicand.
- `i_multiplier`  in  N  upstream multiplier.
- `o_count`  out  log2(DEPTH)+1  FIFO occupancy.
- `o_start`  out  1  one-cycle start pulse to `Multiplier`.
- `o_multiplicand`  out  N  operand to `Multiplier`; stable from the start cycle until the product is captured.
- `o_multiplier`  out  N  operand to `Multiplier`; same stability rule.
- `i_finished`  in  1  `Multiplier` done flag.
- `i_product`  in  2N  `Multiplier` result.
- `o_valid`  out  1  product available downstream.
- `i_ready`  in  1  downstream accepts product.
- `o_product`  out  2N  registered product.

## Operation

- Push: on a clock edge with `i_valid & o_ready`, write `{i_multiplicand, i_multiplier}` at the write pointer.
- `o_ready` derives from registered `o_count` only. A pop in the same cycle does not raise `o_ready` when the FIFO is full.
- Count update: `o_count += push − pop`. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, START, WAIT, HOLD.
  - IDLE: if `o_count != 0`, pop the head into the `o_multiplicand`/`o_multiplier` registers and go to START. Otherwise stay in IDLE.
  - START: `o_start` is 1 for exactly this cycle. Next state is WAIT unconditionally. `i_finished` is ignored in this state.
  - WAIT: on an edge with `i_finished == 1`, load `o_product <= i_product` and `o_valid <= 1`, then go to HOLD.
  - HOLD: `o_valid` stays 1 and `o_product` is stable. On an edge with `i_ready == 1`, clear `o_valid` and go to IDLE.
- Products leave in push order. No arithmetic is performed locally; `o_product` is exactly `i_product`, zero-extended width `2N`.
- Reset (`i_reset == 0`, asynchronous): state IDLE, FIFO emptied, pointers 0.
  - `o_count = 0`, `o_ready = 1`, `o_start = 0`, `o_valid = 0`.
  - `o_product`, `o_multiplicand` and `o_multiplier` are all 0.
  - Reset mid-operation discards queued and in-flight operations with no output. `Multiplier` shares `i_reset`.

## Timing

- For a push accepted at edge t on an empty, idle block:
  - Edge t+1: pop, state START.
  - Cycle after t+1: `o_start` is high.
  - From edge t+2: WAIT.
- If `i_finished` is first high in WAIT at edge f, `o_valid` rises right after edge f.
- If `i_ready` is already high, `o_valid` lasts one cycle. The next dispatch pops at the following edge.
- Minimum spacing between `o_start` pulses: multiplier latency + 3 cycles.
- Throughput is at most one operation in flight; there is no overlap of HOLD with the next START.
- The FIFO accepts a push every cycle until full, independent of FSM state.

## Test plan

- Single op, N=4, 3×5 with `i_ready` held high:
  - Exactly one `o_start` pulse, 2 cycles after the push edge.
  - `o_multiplicand`=3 and `o_multiplier`=5 held through WAIT.
  - `o_product`=15 with `o_valid` high for 1 cycle; `o_count` returns to 0.
- Fill with `i_ready` low and `i_valid` held: push (1,2), (3,4), (5,6), (7,8), (9,10).
  - `o_ready` drops once `o_count`=4.
  - (9,10) is accepted only after the first pop.
- Release `i_ready` after the fill:
  - Products 2, 12, 30, 56, 90 appear in order.
  - Each is stable while `o_valid`=1 and `i_ready`=0.
- Extremes 15×15 and 0×9: `o_product` = 225 (0xE1) and 0.
- Backpressure: hold `i_ready` low 10 cycles with `o_valid` high.
  - `o_product` is unchanged.
  - No further `o_start` occurs.
  - `o_count` is still reported correctly.
- Reset asserted during WAIT with 2 entries queued:
  - Immediately: `o_count`=0, `o_valid`=0, `o_start`=0, `o_ready`=1.
  - After release, a new push of 2×7 yields 14.

Source files
------------

// File: rtl/multiply_dispatcher_if.sv
// Bundles the operand stream, the Multiplier control/result wires and the
// product stream that the dispatcher sits between.
interface multiply_dispatcher_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // upstream operand stream
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_multiplicand;
  logic [N-1:0]     i_multiplier;
  logic [CW-1:0]    o_count;

  // Multiplier side
  logic             o_start;
  logic [N-1:0]     o_multiplicand;
  logic [N-1:0]     o_multiplier;
  logic             i_finished;
  logic [2*N-1:0]   i_product;

  // downstream product stream
  logic             o_valid;
  logic             i_ready;
  logic [2*N-1:0]   o_product;

  // dispatcher side
  modport slave (
    input  i_valid, i_multiplicand, i_multiplier, i_finished, i_product, i_ready,
    output o_ready, o_count, o_start, o_multiplicand, o_multiplier, o_valid, o_product
  );

  // operand source / Multiplier / product sink side
  modport master (
    output i_valid, i_multiplicand, i_multiplier, i_finished, i_product, i_ready,
    input  o_ready, o_count, o_start, o_multiplicand, o_multiplier, o_valid, o_product
  );
endinterface

// File: rtl/multiply_dispatcher.sv
// Operand FIFO in front of a sequential Multiplier: issues one operand pair at a
// time with a start pulse and returns products in order on a valid/ready stream.
module multiply_dispatcher #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  multiply_dispatcher_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 2 * N;
  localparam int unsigned PW = 2 * N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ready_q;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          start_q;
  logic          start_d;
  logic          valid_q;
  logic          valid_d;
  logic          pop;
  logic          load_product;
  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [PW-1:0] product_q;

  logic          push;

  // ready reflects only the registered occupancy, so a pop never opens a full FIFO early
  assign push    = bus.i_valid & ready_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.i_multiplicand, bus.i_multiplier};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load_product = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_finished) begin
          load_product = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    start_d = (state_d == S_START);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      valid_q <= valid_d;
      // operands stay put from the pop until the next pop, covering START..HOLD
      if (pop) begin
        {mcand_q, mplier_q} <= mem[rd_ptr];
      end
      if (load_product) begin
        product_q <= bus.i_product;
      end
    end
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_count        = count_q;
  assign bus.o_start        = start_q;
  assign bus.o_multiplicand = mcand_q;
  assign bus.o_multiplier   = mplier_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_product      = product_q;
endmodule

// File: tb/tb_multiply_dispatcher.sv
// Directed bench for multiply_dispatcher with a small sequential Multiplier model.
module tb_multiply_dispatcher;
  localparam int unsigned N   = 4;
  localparam int unsigned DEP = 4;
  localparam int          LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiply_dispatcher_if #(.N(N), .DEPTH(DEP)) bus ();

  multiply_dispatcher #(.N(N), .DEPTH(DEP)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;

  always @(posedge clk) if (bus.o_start === 1'b1) start_cnt++;

  // Multiplier model: finished rises LAT edges after the start edge and holds until the next start
  logic       m_busy;
  int         m_cnt;
  logic [3:0] m_a, m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy         <= 1'b0;
      m_cnt          <= 0;
      m_a            <= '0;
      m_b            <= '0;
      bus.i_finished <= 1'b0;
      bus.i_product  <= '0;
    end else if (bus.o_start) begin
      m_busy         <= 1'b1;
      m_cnt          <= LAT - 1;
      m_a            <= bus.o_multiplicand;
      m_b            <= bus.o_multiplier;
      bus.i_finished <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy         <= 1'b0;
        bus.i_finished <= 1'b1;
        bus.i_product  <= {4'b0, m_a} * {4'b0, m_b};
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (bus.o_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b);
    bus.i_valid        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.o_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.o_start); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", bus.o_product); end
    checks++; if (bus.o_multiplicand !== 4'd0) begin failures++; $display("FAIL reset_mcand got=%0d exp=0", bus.o_multiplicand); end
    checks++; if (bus.o_multiplier !== 4'd0) begin failures++; $display("FAIL reset_mplier got=%0d exp=0", bus.o_multiplier); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int s0;
    bit ok;
    s0 = start_cnt;
    bus.i_ready = 1'b1;
    push_one(4'd3, 4'd5);
    checks++; if (bus.o_start !== 1'b0 || bus.o_count !== 3'd1) begin failures++; $display("FAIL single_t0 start=%b count=%0d exp start=0 count=1", bus.o_start, bus.o_count); end
    step();
    checks++; if (bus.o_start !== 1'b1 || bus.o_count !== 3'd0) begin failures++; $display("FAIL single_start start=%b count=%0d exp start=1 count=0", bus.o_start, bus.o_count); end
    step();
    checks++; if (bus.o_start !== 1'b0) begin failures++; $display("FAIL single_start_width got=%b exp=0", bus.o_start); end
    checks++; if (bus.o_multiplicand !== 4'd3 || bus.o_multiplier !== 4'd5) begin failures++; $display("FAIL single_ops_wait got=%0d,%0d exp=3,5", bus.o_multiplicand, bus.o_multiplier); end
    wait_valid(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout valid=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_multiplicand !== 4'd3 || bus.o_multiplier !== 4'd5) begin failures++; $display("FAIL single_ops_held got=%0d,%0d exp=3,5", bus.o_multiplicand, bus.o_multiplier); end
    checks++; if (bus.o_product !== 8'd15) begin failures++; $display("FAIL single_product got=%0d exp=15", bus.o_product); end
    step();
    checks++; if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin failures++; $display("FAIL single_done valid=%b count=%0d exp valid=0 count=0", bus.o_valid, bus.o_count); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", start_cnt - s0); end
  endtask

  task automatic test_fill();
    logic [3:0] mc [5];
    logic [3:0] ml [5];
    int idx, guard;
    logic r;
    bit ok;
    mc = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
    ml = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
    bus.i_ready = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 40) begin
      bus.i_valid        = 1'b1;
      bus.i_multiplicand = mc[idx];
      bus.i_multiplier   = ml[idx];
      r = bus.o_ready;
      step();
      if (r) begin
        if (idx == 4) begin
          checks++; if (bus.o_multiplicand !== 4'd1) begin failures++; $display("FAIL fill_first_pop mcand=%0d exp=1", bus.o_multiplicand); end
        end
        idx++;
      end
      guard++;
    end
    bus.i_valid = 1'b0;
    checks++; if (idx !== 5) begin failures++; $display("FAIL fill_accepted got=%0d exp=5", idx); end
    checks++; if (bus.o_count !== 3'd4 || bus.o_ready !== 1'b0) begin failures++; $display("FAIL fill_full count=%0d ready=%b exp count=4 ready=0", bus.o_count, bus.o_ready); end
    wait_valid(20, ok);
    step();
    checks++; if (!ok || bus.o_count !== 3'd4 || bus.o_ready !== 1'b0) begin failures++; $display("FAIL fill_hold ok=%b count=%0d ready=%b exp ok=1 count=4 ready=0", ok, bus.o_count, bus.o_ready); end
  endtask

  task automatic test_release();
    logic [7:0] exp_p [5];
    bit ok;
    exp_p = '{8'd2, 8'd12, 8'd30, 8'd56, 8'd90};
    for (int k = 0; k < 5; k++) begin
      wait_valid(30, ok);
      checks++; if (!ok || bus.o_product !== exp_p[k]) begin failures++; $display("FAIL release_product idx=%0d got=%0d valid=%b exp=%0d", k, bus.o_product, bus.o_valid, exp_p[k]); end
      repeat (2) begin
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_product !== exp_p[k]) begin failures++; $display("FAIL release_stable idx=%0d got=%0d valid=%b exp=%0d", k, bus.o_product, bus.o_valid, exp_p[k]); end
      end
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL release_drop idx=%0d valid=%b exp=0", k, bus.o_valid); end
    end
    repeat (2) step();
    checks++; if (bus.o_count !== 3'd0 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL release_empty count=%0d ready=%b exp count=0 ready=1", bus.o_count, bus.o_ready); end
  endtask

  task automatic test_extremes();
    bit ok;
    bus.i_ready = 1'b1;
    push_one(4'd15, 4'd15);
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'hE1) begin failures++; $display("FAIL extreme_max got=%0d exp=225", bus.o_product); end
    step();
    push_one(4'd0, 4'd9);
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'd0) begin failures++; $display("FAIL extreme_zero got=%0d exp=0", bus.o_product); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int s;
    bus.i_ready = 1'b0;
    push_one(4'd4, 4'd4);
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'd16) begin failures++; $display("FAIL bp_first got=%0d exp=16", bus.o_product); end
    push_one(4'd2, 4'd3);
    push_one(4'd1, 4'd1);
    s = start_cnt;
    repeat (10) begin
      step();
      checks++; if (bus.o_valid !== 1'b1 || bus.o_product !== 8'd16) begin failures++; $display("FAIL bp_hold got=%0d valid=%b exp=16", bus.o_product, bus.o_valid); end
      checks++; if (bus.o_count !== 3'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", bus.o_count); end
    end
    checks++; if (start_cnt !== s) begin failures++; $display("FAIL bp_no_start got=%0d exp=%0d", start_cnt, s); end
    bus.i_ready = 1'b1;
    step();
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'd6) begin failures++; $display("FAIL bp_second got=%0d exp=6", bus.o_product); end
    step();
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'd1) begin failures++; $display("FAIL bp_third got=%0d exp=1", bus.o_product); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.i_ready = 1'b1;
    push_one(4'd5, 4'd5);
    push_one(4'd6, 4'd6);
    push_one(4'd7, 4'd7);
    checks++; if (bus.o_count !== 3'd2 || bus.o_start !== 1'b0) begin failures++; $display("FAIL mid_pre count=%0d start=%b exp count=2 start=0", bus.o_count, bus.o_start); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_count !== 3'd0 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_fifo count=%0d ready=%b exp count=0 ready=1", bus.o_count, bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0 || bus.o_start !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl valid=%b start=%b exp 0,0", bus.o_valid, bus.o_start); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (bus.o_count !== 3'd0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_after count=%0d valid=%b exp 0,0", bus.o_count, bus.o_valid); end
    push_one(4'd2, 4'd7);
    wait_valid(20, ok);
    checks++; if (!ok || bus.o_product !== 8'd14) begin failures++; $display("FAIL mid_new_op got=%0d exp=14", bus.o_product); end
    step();
  endtask

  initial begin
    bus.i_valid        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;
    bus.i_ready        = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_release();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
